// File: rtl/rv32i_types.sv
// Shared RV32I encodings and instruction-generator types.
// Opcode index constants follow the opcode_seen bit order.
package rv32i_types;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_REG   = 7'b0110011;

  localparam logic [6:0]  F7_BASE = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [3:0] OPI_LUI   = 4'd0;
  localparam logic [3:0] OPI_AUIPC = 4'd1;
  localparam logic [3:0] OPI_JAL   = 4'd2;
  localparam logic [3:0] OPI_JALR  = 4'd3;
  localparam logic [3:0] OPI_BR    = 4'd4;
  localparam logic [3:0] OPI_LOAD  = 4'd5;
  localparam logic [3:0] OPI_STORE = 4'd6;
  localparam logic [3:0] OPI_IMM   = 4'd7;
  localparam logic [3:0] OPI_REG   = 4'd8;

  localparam logic [31:0] INSTR_GEN_LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    IG_IDLE,
    IG_GEN,
    IG_HOLD,
    IG_DONE
  } instr_gen_state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  // Shared by store and branch: same field split.
  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef union packed {
    r_type_t     r;
    i_type_t     i;
    s_type_t     s;
    u_type_t     u;
    logic [31:0] word;
  } instr_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? INSTR_GEN_LFSR_MASK : 32'h0);
  endfunction

  function automatic logic [3:0] op_idx(input logic [3:0] sel);
    logic [3:0] idx;
    idx = OPI_REG;
    unique case (1'b1)
      sel < 4'd7:                 idx = sel;
      sel >= 4'd7 && sel < 4'd12: idx = OPI_IMM;
      sel >= 4'd12:               idx = OPI_REG;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR with step enable.
// A zero seed is replaced by 1 so the register never locks up.
module lfsr32
  import rv32i_types::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [31:0] state
);

  localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/rv32i_instr_gen.sv
// Constrained-random RV32I instruction stream over valid/ready.
// INSTR_GEN_ALIGN_EN aligns load/store/branch/jump immediates.
module rv32i_instr_gen
  import rv32i_types::*;
#(
  parameter logic [31:0] SEED = 32'hECEB_0411
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] count,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        busy,
  output logic        done,
  output logic [8:0]  opcode_seen
);

  function automatic instr_t encode(input logic [31:0] l);
    instr_t w;
    logic [2:0] f3;
    f3 = l[14:12];
    w.word = NOP_WORD;
    case (op_idx(l[3:0]))
      OPI_LUI: begin
        w.u.imm    = l[31:12];
        w.u.rd     = l[11:7];
        w.u.opcode = OPC_LUI;
      end
      OPI_AUIPC: begin
        w.u.imm    = l[31:12];
        w.u.rd     = l[11:7];
        w.u.opcode = OPC_AUIPC;
      end
      OPI_JAL: begin
        w.u.imm    = l[31:12];
        w.u.rd     = l[11:7];
        w.u.opcode = OPC_JAL;
`ifdef INSTR_GEN_ALIGN_EN
        w.u.imm[9] = 1'b0;
`endif
      end
      OPI_JALR: begin
        w.i.imm    = l[31:20];
        w.i.rs1    = l[19:15];
        w.i.funct3 = 3'b000;
        w.i.rd     = l[11:7];
        w.i.opcode = OPC_JALR;
`ifdef INSTR_GEN_ALIGN_EN
        w.i.imm[1:0] = 2'b00;
`endif
      end
      OPI_BR: begin
        w.s.imm_hi = l[31:25];
        w.s.rs2    = l[24:20];
        w.s.rs1    = l[19:15];
        w.s.funct3 = (f3[2:1] == 2'b01) ? {2'b00, f3[0]} : f3;
        w.s.imm_lo = l[11:7];
        w.s.opcode = OPC_BR;
`ifdef INSTR_GEN_ALIGN_EN
        w.s.imm_lo[1] = 1'b0;
`endif
      end
      OPI_LOAD: begin
        w.i.imm    = l[31:20];
        w.i.rs1    = l[19:15];
        w.i.funct3 = (f3 == 3'b011 || f3[2:1] == 2'b11) ? 3'b010 : f3;
        w.i.rd     = l[11:7];
        w.i.opcode = OPC_LOAD;
`ifdef INSTR_GEN_ALIGN_EN
        if (w.i.funct3 == 3'b010) w.i.imm[1:0] = 2'b00;
        else if (w.i.funct3[1:0] == 2'b01) w.i.imm[0] = 1'b0;
`endif
      end
      OPI_STORE: begin
        w.s.imm_hi = l[31:25];
        w.s.rs2    = l[24:20];
        w.s.rs1    = l[19:15];
        w.s.funct3 = (f3[2] | (f3[1] & f3[0])) ? 3'b010 : f3;
        w.s.imm_lo = l[11:7];
        w.s.opcode = OPC_STORE;
`ifdef INSTR_GEN_ALIGN_EN
        if (w.s.funct3 == 3'b010) w.s.imm_lo[1:0] = 2'b00;
        else if (w.s.funct3 == 3'b001) w.s.imm_lo[0] = 1'b0;
`endif
      end
      OPI_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shifts: rs2 slot carries shamt, funct7 selects srli/srai.
          w.r.funct7 = (f3 == 3'b101 && l[30]) ? F7_ALT : F7_BASE;
          w.r.rs2    = l[24:20];
          w.r.rs1    = l[19:15];
          w.r.funct3 = f3;
          w.r.rd     = l[11:7];
          w.r.opcode = OPC_IMM;
        end else begin
          w.i.imm    = l[31:20];
          w.i.rs1    = l[19:15];
          w.i.funct3 = f3;
          w.i.rd     = l[11:7];
          w.i.opcode = OPC_IMM;
        end
      end
      OPI_REG: begin
        w.r.funct7 = ((f3 == 3'b000 || f3 == 3'b101) && l[30])
                     ? F7_ALT : F7_BASE;
        w.r.rs2    = l[24:20];
        w.r.rs1    = l[19:15];
        w.r.funct3 = f3;
        w.r.rd     = l[11:7];
        w.r.opcode = OPC_REG;
      end
      default: w.word = NOP_WORD;
    endcase
    return w;
  endfunction

  instr_gen_state_t state_q, state_d;
  instr_t           instr_q;
  logic [15:0]      remaining_q;
  logic [8:0]       seen_q;
  logic [31:0]      lfsr_state;
  logic [31:0]      lfsr_next;
  logic             xfer;
  logic             last;
  logic             step;

  assign xfer      = instr_valid & instr_ready;
  assign last      = remaining_q == 16'd1;
  assign step      = (state_q == IG_GEN) | (xfer & ~last);
  assign lfsr_next = lfsr_step(lfsr_state);

  lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step),
    .state(lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IG_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IG_IDLE: begin
        if (start) state_d = (count != 16'd0) ? IG_GEN : IG_DONE;
      end
      IG_GEN:  state_d = IG_HOLD;
      IG_HOLD: begin
        if (xfer && last) state_d = IG_DONE;
      end
      IG_DONE: state_d = IG_IDLE;
      default: state_d = IG_IDLE;
    endcase
  end

  always_comb begin
    instr_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IG_GEN:  busy = 1'b1;
      IG_HOLD: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
      end
      IG_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q.word <= NOP_WORD;
      remaining_q  <= 16'd0;
      seen_q       <= 9'd0;
    end else begin
      if (state_q == IG_IDLE && start && count != 16'd0) begin
        remaining_q <= count;
        seen_q      <= 9'd0;
      end
      if (xfer) remaining_q <= remaining_q - 16'd1;
      if (step) begin
        instr_q <= encode(lfsr_next);
        seen_q  <= seen_q | (9'd1 << op_idx(lfsr_next[3:0]));
      end
    end
  end

  assign instr       = instr_q.word;
  assign opcode_seen = seen_q;

endmodule
